alu_rr_sched: RTL and testbench



---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_core.sv | 40 ++++
 rtl/alu_rr_sched.sv | 111 +++++++++++
 tb/tb_alu_rr_sched.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op encodings, divide-by-zero result and scheduler state encoding.
// Used by the scheduler and by alu_core.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [7:0] DIV0_RESULT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational add/sub/mul/div on zero-extended operands; zero latency, no flow control.
// A zero divisor returns DIV0_RESULT and raises div0.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int RES_W  = 8
) (
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [RES_W-1:0]  c,
  output logic              div0
);

  logic [RES_W-1:0] ax;
  logic [RES_W-1:0] bx;

  always_comb begin
    ax   = RES_W'(a);
    bx   = RES_W'(b);
    c    = '0;
    div0 = 1'b0;
    case (sel)
      OP_ADD: c = ax + bx;
      OP_SUB: c = ax - bx;
      OP_MUL: c = ax * bx;
      OP_DIV: begin
        if (b == '0) begin
          c    = RES_W'(DIV0_RESULT);
          div0 = 1'b1;
        end else begin
          c = ax / bx;
        end
      end
      default: c = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin share of one ALU between two requesters; result is registered 2 cycles after accept.
// Requests are accepted only in IDLE; the response holds stable under rsp_ready backpressure.
module alu_rr_sched
  import alu_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int RES_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_err,
  output logic              busy
);

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic              gnt_any;
  logic              gnt_id;
  logic              accept;
  logic [1:0]        lat_op;
  logic [DATA_W-1:0] lat_a;
  logic [DATA_W-1:0] lat_b;
  logic              lat_id;
  logic [RES_W-1:0]  alu_c;
  logic              alu_div0;

  // On contention the requester that did not win last time is picked.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    gnt_id  = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = gnt_any & ~gnt_id;
        req1_ready = gnt_id;
        accept     = gnt_any;
        if (gnt_any) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      lat_op     <= OP_ADD;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_id     <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        last_grant <= gnt_id;
        lat_id     <= gnt_id;
        lat_op     <= gnt_id ? req1_op : req0_op;
        lat_a      <= gnt_id ? req1_a  : req0_a;
        lat_b      <= gnt_id ? req1_b  : req0_b;
      end
      if (state == EXEC) begin
        rsp_id     <= lat_id;
        rsp_result <= alu_c;
        rsp_err    <= alu_div0;
      end
    end
  end

  alu_core #(
    .DATA_W(DATA_W),
    .RES_W (RES_W)
  ) u_alu_core (
    .sel (lat_op),
    .a   (lat_a),
    .b   (lat_b),
    .c   (alu_c),
    .div0(alu_div0)
  );

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_rr_sched.sv
// Randomized and directed stimulus for alu_rr_sched against a transaction-level reference model.
module tb_alu_rr_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [7:0] rsp_result;

  alu_rr_sched #(.DATA_W(4), .RES_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int id; int res; int err;} exp_t;
  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  // Stimulus intent for each requester and the consumer.
  bit v0, v1, rr;
  int op0, a0, b0, op1, a1, b1;
  // Reference model: cycles since accept (-1 = idle) and last winner.
  int age = -1;
  int m_last = 1;
  bit acc0, acc1, got_rsp;
  int cap_id, cap_res, cap_err;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_res(input int op, input int a, input int b);
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return a * b;
      default: return (b == 0) ? 255 : a / b;
    endcase
  endfunction

  task automatic step();
    int   g;
    exp_t e;
    @(negedge clk);
    req0_valid = v0; req0_op = 2'(op0); req0_a = 4'(a0); req0_b = 4'(b0);
    req1_valid = v1; req1_op = 2'(op1); req1_a = 4'(a1); req1_b = 4'(b1);
    rsp_ready  = rr;
    #1;
    acc0 = 0; acc1 = 0; got_rsp = 0;
    if (age < 0) begin
      g = -1;
      if (v0 && v1) g = (m_last == 1) ? 0 : 1;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
      chk("req0_ready", req0_ready, g == 0);
      chk("req1_ready", req1_ready, g == 1);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_busy", busy, 0);
      if (g >= 0) begin
        e.id  = g;
        e.res = (g == 1) ? ref_res(op1, a1, b1) : ref_res(op0, a0, b0);
        e.err = (g == 1) ? int'(op1 == 3 && b1 == 0) : int'(op0 == 3 && b0 == 0);
        exp_q.push_back(e);
        m_last = g;
        age = 1;
        if (g == 0) acc0 = 1; else acc1 = 1;
      end
    end else begin
      chk("busy_req0_ready", req0_ready, 0);
      chk("busy_req1_ready", req1_ready, 0);
      chk("busy", busy, 1);
      if (age == 1) begin
        chk("exec_rsp_valid", rsp_valid, 0);
        age = 2;
      end else begin
        chk("rsp_valid", rsp_valid, 1);
        if (exp_q.size() != 0) begin
          chk("rsp_id", rsp_id, exp_q[0].id);
          chk("rsp_result", rsp_result, exp_q[0].res);
          chk("rsp_err", rsp_err, exp_q[0].err);
        end
        if (rr) begin
          cap_id = rsp_id; cap_res = rsp_result; cap_err = rsp_err;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          age = -1;
          got_rsp = 1;
        end
      end
    end
  endtask

  task automatic run_op(input int id, input int op, input int a, input int b);
    int k;
    if (id == 0) begin v0 = 1; op0 = op; a0 = a; b0 = b; end
    else         begin v1 = 1; op1 = op; a1 = a; b1 = b; end
    rr = 1;
    k = 0; acc0 = 0; acc1 = 0;
    while (!(acc0 || acc1) && k < 10) begin step(); k++; end
    if (!(acc0 || acc1)) chk("accept_timeout", 0, 1);
    v0 = 0; v1 = 0;
    k = 0; got_rsp = 0;
    while (!got_rsp && k < 20) begin step(); k++; end
    if (!got_rsp) chk("rsp_timeout", 0, 1);
  endtask

  task automatic model_reset();
    age = -1; m_last = 1; exp_q.delete();
  endtask

  initial begin
    int k, ng;
    int grants[4];
    v0 = 0; v1 = 0; rr = 1;
    op0 = 0; a0 = 0; b0 = 0; op1 = 0; a1 = 0; b1 = 0;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    rsp_ready = 1;
    rst_n = 0;
    #23;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    @(negedge clk); rst_n = 1;
    model_reset();

    // Both requesters contend continuously from reset: expect 0,1,0,1.
    v0 = 1; op0 = 0; a0 = 1; b0 = 2;
    v1 = 1; op1 = 2; a1 = 3; b1 = 4;
    ng = 0; k = 0;
    while (ng < 4 && k < 40) begin
      step(); k++;
      if (acc0) begin grants[ng] = 0; ng++; a0 = a0 + 2; end
      if (acc1) begin grants[ng] = 1; ng++; b1 = b1 + 3; end
    end
    if (ng < 4) chk("grant_timeout", ng, 4);
    for (int i = 0; i < ng; i++) chk("grant_order", grants[i], i % 2);
    v0 = 0; v1 = 0;
    k = 0;
    while (age >= 0 && k < 10) begin step(); k++; end

    run_op(0, 0, 9, 7);
    chk("t1_id", cap_id, 0); chk("t1_res", cap_res, 16); chk("t1_err", cap_err, 0);
    run_op(1, 1, 3, 5);
    chk("t2_id", cap_id, 1); chk("t2_res", cap_res, 8'hFE);
    run_op(1, 2, 15, 15);
    chk("t2_mul", cap_res, 225);
    run_op(0, 3, 12, 0);
    chk("t4_div0_res", cap_res, 8'hFF); chk("t4_div0_err", cap_err, 1);
    run_op(0, 3, 12, 5);
    chk("t4_div_res", cap_res, 2); chk("t4_div_err", cap_err, 0);

    // Backpressure: hold the response for five cycles while both requesters wait.
    rr = 0; v0 = 1; op0 = 2; a0 = 7; b0 = 6;
    k = 0; acc0 = 0;
    while (!acc0 && k < 10) begin step(); k++; end
    if (!acc0) chk("bp_accept_timeout", 0, 1);
    v0 = 0;
    step();
    v0 = 1; v1 = 1; op0 = 0; a0 = 1; b0 = 1; op1 = 0; a1 = 2; b1 = 2;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_result", rsp_result, 42);
    end
    v0 = 0; v1 = 0; rr = 1;
    step();
    chk("bp_release", got_rsp, 1);
    step();
    chk("bp_idle_busy", busy, 0);

    // Reset during EXEC after req0 won, then contention must still go to req0.
    v0 = 1; op0 = 2; a0 = 5; b0 = 5;
    k = 0; acc0 = 0;
    while (!acc0 && k < 10) begin step(); k++; end
    if (!acc0) chk("rst_accept_timeout", 0, 1);
    v0 = 0;
    @(posedge clk); #2;
    req0_valid = 0; req1_valid = 0;
    chk("exec_busy_before_rst", busy, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req0_ready", req0_ready, 0);
    model_reset();
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_no_rsp", rsp_valid, 0);
    end
    v0 = 1; v1 = 1; op0 = 1; a0 = 4; b0 = 9; op1 = 3; a1 = 9; b1 = 2;
    step();
    chk("post_rst_grant0", acc0, 1);
    v0 = 0;
    k = 0; acc1 = 0;
    while (!acc1 && k < 10) begin step(); k++; end
    if (!acc1) chk("post_rst_req1_timeout", 0, 1);
    v1 = 0;

    // Random traffic: requesters hold until accepted, consumer stalls randomly.
    for (int i = 0; i < 400; i++) begin
      if (!v0 && $urandom_range(0, 9) < 6) begin
        v0 = 1; op0 = $urandom_range(0, 3); a0 = $urandom_range(0, 15); b0 = $urandom_range(0, 15);
      end
      if (!v1 && $urandom_range(0, 9) < 6) begin
        v1 = 1; op1 = $urandom_range(0, 3); a1 = $urandom_range(0, 15); b1 = $urandom_range(0, 15);
      end
      rr = ($urandom_range(0, 3) != 0);
      step();
      if (acc0) v0 = 0;
      if (acc1) v1 = 0;
    end
    v0 = 0; v1 = 0; rr = 1;
    k = 0;
    while (age >= 0 && k < 10) begin step(); k++; end
    if (age >= 0) chk("drain_timeout", 0, 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
